// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI mode-0 peripheral.
package spi_pkg;

   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

   localparam int unsigned DEFAULT_FRAME_WIDTH = 8;
   localparam int unsigned MAX_FRAME_WIDTH     = 15;
   localparam logic [MAX_FRAME_WIDTH-1:0] DEFAULT_FILL_WORD = '1;
   localparam int unsigned SYNC_STAGES         = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } spi_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous pin, with rise/fall detection
// against one further registered copy of the synchronized level.
module sync_edge_detect
   import spi_pkg::*;
#(
   parameter int unsigned STAGES    = SYNC_STAGES,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= {STAGES{RESET_VAL}};
         r_prev <= RESET_VAL;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_async};
         r_prev <= r_sync[STAGES-1];
      end
   end

   assign o_level = r_sync[STAGES-1];
   assign o_rise  =  r_sync[STAGES-1] & ~r_prev;
   assign o_fall  = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 target, fully oversampled by clk: receives frames on mosi,
// returns response words on miso, back-to-back frames without cs_n toggling.
module spi_peripheral
   import spi_pkg::*;
#(
   parameter int unsigned                FRAME_WIDTH = DEFAULT_FRAME_WIDTH,
   parameter logic [FRAME_WIDTH-1:0]     FILL_WORD   = DEFAULT_FILL_WORD[FRAME_WIDTH-1:0]
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   sclk,
   input  logic                   cs_n,
   input  logic                   mosi,
   output logic                   miso,
   output logic                   miso_oe,
   input  logic [FRAME_WIDTH-1:0] tx_word,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   output logic                   tx_underrun,
   output logic [FRAME_WIDTH-1:0] rx_word,
   output logic                   rx_valid,
   output logic                   frame_error,
   output logic                   busy
);

   localparam int unsigned CNT_W = $clog2(FRAME_WIDTH);

   logic w_sclk_level_unused, w_sclk_rise, w_sclk_fall;
   logic w_cs_level_unused, w_cs_rise, w_cs_fall;
   logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

   sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sync_sclk (
      .i_clk(clk), .i_rst_n(reset_n), .i_async(sclk),
      .o_level(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
   );

   sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .i_clk(clk), .i_rst_n(reset_n), .i_async(cs_n),
      .o_level(w_cs_level_unused), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
   );

   sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_mosi (
      .i_clk(clk), .i_rst_n(reset_n), .i_async(mosi),
      .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
   );

   spi_state_e             r_state, w_state_nxt;
   logic [CNT_W-1:0]       r_bit_cnt;
   logic [FRAME_WIDTH-1:0] r_shift_in, r_shift_out, r_rx_word;
   logic                   r_rx_valid, r_frame_error, r_miso, r_miso_oe;
   logic                   r_wrapped;

   logic                   w_load, w_sample, w_fall_shift, w_abort;
   logic                   w_last_bit;
   logic [FRAME_WIDTH-1:0] w_load_word, w_in_word;

   assign w_last_bit  = (r_bit_cnt == CNT_W'(FRAME_WIDTH - 1));
   assign w_load_word = tx_valid ? tx_word : FILL_WORD;
   assign w_in_word   = {r_shift_in[FRAME_WIDTH-2:0], w_mosi};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // cs_n deassertion is checked first so it discards any sclk edge in the same cycle.
   // A fall with bit_cnt==0 is a frame boundary only after a completed frame (r_wrapped).
   always_comb begin
      w_state_nxt  = r_state;
      tx_ready     = 1'b0;
      tx_underrun  = 1'b0;
      w_load       = 1'b0;
      w_sample     = 1'b0;
      w_fall_shift = 1'b0;
      w_abort      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            tx_ready    = 1'b1;
            tx_underrun = ~tx_valid;
            if (w_cs_rise) begin
               w_abort     = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_load      = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_cs_rise) begin
               w_abort     = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_sclk_rise) begin
               w_sample = 1'b1;
            end else if (w_sclk_fall) begin
               if (r_bit_cnt != '0) w_fall_shift = 1'b1;
               else if (r_wrapped)  w_state_nxt  = ST_LOAD;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bit_cnt     <= '0;
         r_shift_in    <= '0;
         r_shift_out   <= '1;
         r_rx_word     <= '1;
         r_rx_valid    <= 1'b0;
         r_frame_error <= 1'b0;
         r_miso        <= 1'b1;
         r_miso_oe     <= 1'b0;
         r_wrapped     <= 1'b0;
      end else begin
         r_rx_valid    <= 1'b0;
         r_frame_error <= 1'b0;
         if (w_abort) begin
            r_frame_error <= (r_bit_cnt != '0);
            r_bit_cnt     <= '0;
            r_miso        <= 1'b1;
            r_miso_oe     <= 1'b0;
            r_wrapped     <= 1'b0;
         end else if (w_load) begin
            r_shift_out <= w_load_word;
            r_miso      <= w_load_word[FRAME_WIDTH-1];
            r_miso_oe   <= 1'b1;
            r_wrapped   <= 1'b0;
         end else if (w_sample) begin
            r_shift_in <= w_in_word;
            if (w_last_bit) begin
               r_rx_word  <= w_in_word;
               r_rx_valid <= 1'b1;
               r_bit_cnt  <= '0;
               r_wrapped  <= 1'b1;
            end else begin
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
         end else if (w_fall_shift) begin
            r_shift_out <= {r_shift_out[FRAME_WIDTH-2:0], 1'b1};
            r_miso      <= r_shift_out[FRAME_WIDTH-2];
         end
      end
   end

   assign miso        = r_miso;
   assign miso_oe     = r_miso_oe;
   assign rx_word     = r_rx_word;
   assign rx_valid    = r_rx_valid;
   assign frame_error = r_frame_error;
   assign busy        = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: acts as a mode-0 controller at clk/8
// and checks reset state, framing, underrun, abort and reset-mid-frame cases.
module tb_spi_peripheral;

   logic       clk = 1'b0;
   logic       reset_n, sclk, cs_n, mosi;
   logic       miso, miso_oe;
   logic [7:0] tx_word, rx_word;
   logic       tx_valid, tx_ready, tx_underrun, rx_valid, frame_error, busy;

   int unsigned n_checks = 0, n_pass = 0;
   int unsigned n_ready = 0, n_under = 0, n_rxv = 0, n_ferr = 0;
   int unsigned snap_ready, snap_under, snap_rxv;
   logic [7:0]  rx_log[$];
   logic [7:0]  rxb, rxb2;

   always #5 clk = ~clk;

   spi_peripheral #(.FRAME_WIDTH(8), .FILL_WORD(8'hFF)) dut (
      .clk(clk), .reset_n(reset_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .tx_word(tx_word), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_underrun(tx_underrun), .rx_word(rx_word),
      .rx_valid(rx_valid), .frame_error(frame_error), .busy(busy)
   );

   always @(negedge clk) begin
      if (tx_ready)    n_ready++;
      if (tx_underrun) n_under++;
      if (frame_error) n_ferr++;
      if (rx_valid) begin
         n_rxv++;
         rx_log.push_back(rx_word);
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic wait_clk(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_counts();
      n_ready = 0;
      n_under = 0;
      n_rxv   = 0;
      n_ferr  = 0;
      rx_log.delete();
   endtask

   // Mode 0 controller: mosi set on the fall, miso sampled at the rise, 4 clk per half period.
   task automatic spi_xfer(input logic [7:0] tx, input int unsigned nbits, output logic [7:0] rx);
      rx = '0;
      for (int unsigned i = 0; i < nbits; i++) begin
         mosi = tx[7-i];
         wait_clk(4);
         rx   = {rx[6:0], miso};
         sclk = 1'b1;
         wait_clk(4);
         if (i == nbits - 1) begin
            snap_ready = n_ready;
            snap_under = n_under;
            snap_rxv   = n_rxv;
         end
         sclk = 1'b0;
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      sclk     = 1'b0;
      cs_n     = 1'b1;
      mosi     = 1'b1;
      tx_word  = '0;
      tx_valid = 1'b0;
      wait_clk(3);
      check_val("reset_miso",     miso,     1);
      check_val("reset_miso_oe",  miso_oe,  0);
      check_val("reset_rx_word",  rx_word,  8'hFF);
      check_val("reset_rx_valid", rx_valid, 0);
      check_val("reset_busy",     busy,     0);
      check_val("reset_tx_ready", tx_ready, 0);
      reset_n = 1'b1;
      clear_counts();

      wait_clk(100);
      check_val("idle_miso",    miso,    1);
      check_val("idle_miso_oe", miso_oe, 0);
      check_val("idle_rx_word", rx_word, 8'hFF);
      check_val("idle_pulses",  n_ready + n_under + n_rxv + n_ferr, 0);

      // Single frame: respond A5, receive 3C
      clear_counts();
      tx_word  = 8'hA5;
      tx_valid = 1'b1;
      cs_n     = 1'b0;
      wait_clk(8);
      check_val("f1_busy",    busy,    1);
      check_val("f1_miso_oe", miso_oe, 1);
      spi_xfer(8'h3C, 8, rxb);
      check_val("f1_miso_word", rxb,        8'hA5);
      check_val("f1_tx_ready",  snap_ready, 1);
      check_val("f1_rx_valid",  snap_rxv,   1);
      check_val("f1_rx_word",   rx_log[0],  8'h3C);
      cs_n = 1'b1;
      tx_valid = 1'b0;
      wait_clk(10);
      check_val("f1_idle_busy", busy, 0);

      // Back-to-back frames without tx_valid
      clear_counts();
      cs_n = 1'b0;
      wait_clk(8);
      spi_xfer(8'h40, 8, rxb);
      spi_xfer(8'h95, 8, rxb2);
      check_val("b2b_underrun", snap_under,    2);
      check_val("b2b_miso0",    rxb,           8'hFF);
      check_val("b2b_miso1",    rxb2,          8'hFF);
      check_val("b2b_rx_valid", snap_rxv,      2);
      check_val("b2b_rx_size",  rx_log.size(), 2);
      check_val("b2b_rx0",      rx_log[0],     8'h40);
      check_val("b2b_rx1",      rx_log[1],     8'h95);
      cs_n = 1'b1;
      wait_clk(10);

      // Abort after 5 bits
      clear_counts();
      cs_n = 1'b0;
      wait_clk(8);
      spi_xfer(8'hE7, 5, rxb);
      cs_n = 1'b1;
      wait_clk(4);
      check_val("abort_miso_oe", miso_oe, 0);
      check_val("abort_miso",    miso,    1);
      wait_clk(6);
      check_val("abort_frame_error", n_ferr,  1);
      check_val("abort_rx_valid",    n_rxv,   0);
      check_val("abort_rx_word",     rx_word, 8'h95);

      // Reset mid-frame, then a clean frame
      clear_counts();
      tx_word  = 8'h5A;
      tx_valid = 1'b1;
      cs_n     = 1'b0;
      wait_clk(8);
      spi_xfer(8'h12, 3, rxb);
      reset_n = 1'b0;
      #1;
      check_val("rst_mid_miso",    miso,    1);
      check_val("rst_mid_miso_oe", miso_oe, 0);
      check_val("rst_mid_rx_word", rx_word, 8'hFF);
      check_val("rst_mid_busy",    busy,    0);
      cs_n = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      wait_clk(10);
      check_val("rst_mid_no_pulses", n_ferr + n_rxv, 0);
      clear_counts();
      cs_n = 1'b0;
      wait_clk(8);
      spi_xfer(8'h77, 8, rxb);
      check_val("rst_next_miso",     rxb,       8'h5A);
      check_val("rst_next_rx_valid", snap_rxv,  1);
      check_val("rst_next_rx_word",  rx_log[0], 8'h77);
      cs_n = 1'b1;
      tx_valid = 1'b0;
      wait_clk(10);

      // cs_n rise coincident with the 8th sclk rise
      clear_counts();
      cs_n = 1'b0;
      wait_clk(8);
      spi_xfer(8'hC3, 7, rxb);
      mosi = 1'b1;
      wait_clk(4);
      sclk = 1'b1;
      cs_n = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
      wait_clk(8);
      check_val("coinc_frame_error", n_ferr,  1);
      check_val("coinc_rx_valid",    n_rxv,   0);
      check_val("coinc_rx_word",     rx_word, 8'h77);
      check_val("coinc_miso_oe",     miso_oe, 0);
      check_val("coinc_busy",        busy,    0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
